// File: rtl/btb_predict_pkg.sv
// Shared types and constants for the branch target cache predict side.
package btb_predict_pkg;

    localparam int unsigned NENT_DEF = 8;
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_state_e;

    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [AW_DEF-1:0] next_pc;
    } inflight_t;

endpackage

// File: rtl/btb_predict_lookup.sv
// Combinational priority lookup over the packed entries; lowest hitting index wins.
module btb_lookup
    import btb_predict_pkg::*;
#(
    parameter int unsigned NENT = NENT_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic [AW-1:0]      pc,
    input  logic [NENT-1:0]    ent_valid,
    input  logic [NENT*AW-1:0] ent_tag,
    input  logic [NENT*AW-1:0] ent_target,
    input  logic [NENT*2-1:0]  ent_state,
    output logic               hit_c,
    output logic               taken_c,
    output logic [2:0]         idx_c,
    output logic [AW-1:0]      next_pc_c
);

    logic [AW-1:0] tgt;
    bp_state_e     st;

    // Scan high to low so the lowest matching entry is the last to overwrite.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        tgt   = '0;
        st    = SNT;
        for (int i = int'(NENT) - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_tag[i*AW +: AW] == pc)) begin
                hit_c = 1'b1;
                idx_c = 3'(i);
                tgt   = ent_target[i*AW +: AW];
                st    = bp_state_e'(ent_state[i*2 +: 2]);
            end
        end
        taken_c   = hit_c && ((st == WT) || (st == ST));
        next_pc_c = taken_c ? tgt : pc + AW'(PC_STEP);
    end

endmodule

// File: rtl/btb_predict.sv
// Predict side of the branch target cache: lookup pipeline, in-flight FIFO, resolve/redirect.
// Optional BTB_PREDICT_PERF_EN adds saturating lookup/hit/mispredict counters.
module btb_predict
    import btb_predict_pkg::*;
#(
    parameter int unsigned NENT   = NENT_DEF,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned AW     = AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid,
    input  logic [AW-1:0]      fetch_pc,
    output logic               fetch_ready,
    input  logic [NENT-1:0]    ent_valid,
    input  logic [NENT*AW-1:0] ent_tag,
    input  logic [NENT*AW-1:0] ent_target,
    input  logic [NENT*2-1:0]  ent_state,
    output logic               pred_valid,
    input  logic               pred_ready,
    output logic [AW-1:0]      pred_pc,
    output logic [AW-1:0]      pred_next_pc,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [2:0]         pred_idx,
    input  logic               res_valid,
    input  logic               res_taken,
    input  logic [AW-1:0]      res_target,
    output logic               redirect,
    output logic [AW-1:0]      redirect_pc,
    output logic               q_full,
`ifdef BTB_PREDICT_PERF_EN
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_mispred,
`endif
    output logic               err_underflow
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic          lk_hit, lk_taken;
    logic [2:0]    lk_idx;
    logic [AW-1:0] lk_next;

    btb_lookup #(.NENT(NENT), .AW(AW)) u_lookup (
        .pc         (fetch_pc),
        .ent_valid  (ent_valid),
        .ent_tag    (ent_tag),
        .ent_target (ent_target),
        .ent_state  (ent_state),
        .hit_c      (lk_hit),
        .taken_c    (lk_taken),
        .idx_c      (lk_idx),
        .next_pc_c  (lk_next)
    );

    logic          pred_valid_q, pred_valid_d, pred_hit_q, pred_hit_d, pred_taken_q, pred_taken_d;
    logic [2:0]    pred_idx_q, pred_idx_d;
    logic [AW-1:0] pred_pc_q, pred_pc_d, pred_next_q, pred_next_d;
    inflight_t     fifo_q [QDEPTH];
    inflight_t     fifo_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          redirect_q, redirect_d, err_q, err_d;
    logic [AW-1:0] redirect_pc_q, redirect_pc_d;
`ifdef BTB_PREDICT_PERF_EN
    logic [31:0]   lookups_q, lookups_d, hits_q, hits_d, mispred_q, mispred_d;
`endif

    logic          full, accept, pred_fire, pop, mispred;
    logic [AW-1:0] head_pc, head_next, actual;

    always_comb begin
        full        = (count_q == CW'(QDEPTH));
        pred_fire   = pred_valid_q && pred_ready && !full;
        fetch_ready = !pred_valid_q || pred_fire;
        accept      = fetch_valid && fetch_ready;
        head_pc     = AW'(fifo_q[rd_ptr_q].pc);
        head_next   = AW'(fifo_q[rd_ptr_q].next_pc);
        actual      = res_taken ? res_target : head_pc + AW'(PC_STEP);
        pop         = res_valid && (count_q != '0);
        mispred     = pop && (actual != head_next);
    end

    // Next-state: pipeline register, FIFO with flush-on-mispredict, redirect pulse.
    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_pc_d     = pred_pc_q;
        pred_next_d   = pred_next_q;
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_idx_d    = pred_idx_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        redirect_d    = mispred;
        redirect_pc_d = mispred ? actual : '0;
        err_d         = err_q || (res_valid && (count_q == '0));

        if (mispred) begin
            pred_valid_d = 1'b0;
        end else if (accept) begin
            pred_valid_d = 1'b1;
            pred_pc_d    = fetch_pc;
            pred_next_d  = lk_next;
            pred_hit_d   = lk_hit;
            pred_taken_d = lk_taken;
            pred_idx_d   = lk_idx;
        end else if (pred_fire) begin
            pred_valid_d = 1'b0;
        end

        if (mispred) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pred_fire) begin
                fifo_d[wr_ptr_q].pc      = AW_DEF'(pred_pc_q);
                fifo_d[wr_ptr_q].next_pc = AW_DEF'(pred_next_q);
                wr_ptr_d                 = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(pred_fire) - CW'(pop);
        end
    end

`ifdef BTB_PREDICT_PERF_EN
    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        mispred_d = mispred_q;
        if (accept && (lookups_q != '1))          lookups_d = lookups_q + 32'd1;
        if (accept && lk_hit && (hits_q != '1))   hits_d    = hits_q + 32'd1;
        if (mispred && (mispred_q != '1))         mispred_d = mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            mispred_q <= mispred_d;
        end
    end

    assign perf_lookups = lookups_q;
    assign perf_hits    = hits_q;
    assign perf_mispred = mispred_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_next_q   <= '0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_idx_q    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) fifo_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_pc_q     <= pred_pc_d;
            pred_next_q   <= pred_next_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_idx_q    <= pred_idx_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_pc       = pred_pc_q;
    assign pred_next_pc  = pred_next_q;
    assign pred_hit      = pred_hit_q;
    assign pred_taken    = pred_taken_q;
    assign pred_idx      = pred_idx_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign q_full        = full;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_btb_predict.sv
// Directed bench for btb_predict: lookup, FIFO backpressure, mispredict flush, underflow, reset.
module tb_btb_predict;

    localparam int unsigned NENT = 8;
    localparam int unsigned AW   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fetch_valid, fetch_ready;
    logic [AW-1:0]      fetch_pc;
    logic [NENT-1:0]    ent_valid;
    logic [NENT*AW-1:0] ent_tag, ent_target;
    logic [NENT*2-1:0]  ent_state;
    logic               pred_valid, pred_ready, pred_hit, pred_taken;
    logic [AW-1:0]      pred_pc, pred_next_pc;
    logic [2:0]         pred_idx;
    logic               res_valid, res_taken;
    logic [AW-1:0]      res_target;
    logic               redirect, q_full, err_underflow;
    logic [AW-1:0]      redirect_pc;
`ifdef BTB_PREDICT_PERF_EN
    logic [31:0]        perf_lookups, perf_hits, perf_mispred;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btb_predict #(.NENT(NENT), .QDEPTH(4), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .ent_valid    (ent_valid),
        .ent_tag      (ent_tag),
        .ent_target   (ent_target),
        .ent_state    (ent_state),
        .pred_valid   (pred_valid),
        .pred_ready   (pred_ready),
        .pred_pc      (pred_pc),
        .pred_next_pc (pred_next_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_idx     (pred_idx),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_target   (res_target),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .q_full       (q_full),
`ifdef BTB_PREDICT_PERF_EN
        .perf_lookups (perf_lookups),
        .perf_hits    (perf_hits),
        .perf_mispred (perf_mispred),
`endif
        .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input int i, input logic v, input logic [AW-1:0] tag,
                           input logic [AW-1:0] tgt, input logic [1:0] st);
        ent_valid[i]            = v;
        ent_tag[i*AW +: AW]     = tag;
        ent_target[i*AW +: AW]  = tgt;
        ent_state[i*2 +: 2]     = st;
    endtask

    task automatic do_reset();
        fetch_valid = 1'b0;
        res_valid   = 1'b0;
        rst_n       = 1'b0;
        step();
        rst_n       = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; pred_ready = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        ent_valid = '0; ent_tag = '0; ent_target = '0; ent_state = '0;
        step(); step();
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_q_full", 32'(q_full), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_pred_next", pred_next_pc, 32'h0);
        rst_n = 1'b1;

        // Taken hit on entry 2
        set_ent(2, 1'b1, 32'h40, 32'h100, 2'd3);
        fetch_valid = 1'b1; fetch_pc = 32'h40;
        step();
        fetch_valid = 1'b0;
        chk("a_valid", 32'(pred_valid), 32'd1);
        chk("a_hit", 32'(pred_hit), 32'd1);
        chk("a_taken", 32'(pred_taken), 32'd1);
        chk("a_idx", 32'(pred_idx), 32'd2);
        chk("a_next", pred_next_pc, 32'h100);
        chk("a_hold_ready", 32'(fetch_ready), 32'd0);
        do_reset();

        // Weakly not-taken hit, then a miss, back to back
        set_ent(2, 1'b1, 32'h40, 32'h100, 2'd1);
        pred_ready = 1'b1;
        fetch_valid = 1'b1; fetch_pc = 32'h40;
        step();
        chk("b_hit", 32'(pred_hit), 32'd1);
        chk("b_taken", 32'(pred_taken), 32'd0);
        chk("b_next", pred_next_pc, 32'h44);
        chk("b_ready", 32'(fetch_ready), 32'd1);
        fetch_pc = 32'h80;
        step();
        fetch_valid = 1'b0;
        chk("b_miss_hit", 32'(pred_hit), 32'd0);
        chk("b_miss_idx", 32'(pred_idx), 32'd0);
        chk("b_miss_next", pred_next_pc, 32'h84);
        step();
        chk("b_drained", 32'(pred_valid), 32'd0);
        res_valid = 1'b1; res_taken = 1'b0;
        step(); step();
        res_valid = 1'b0;
        chk("b_no_redirect", 32'(redirect), 32'd0);
        step();
        chk("b_no_err", 32'(err_underflow), 32'd0);
        do_reset();

        // Wraparound next-PC on a miss
        fetch_valid = 1'b1; fetch_pc = 32'hFFFF_FFFC;
        step();
        fetch_valid = 1'b0;
        chk("wrap_next", pred_next_pc, 32'h0);
        do_reset();

        // Two hitting entries: lowest index wins
        set_ent(2, 1'b0, 32'h40, 32'h100, 2'd1);
        set_ent(1, 1'b1, 32'h200, 32'h300, 2'd3);
        set_ent(5, 1'b1, 32'h200, 32'h500, 2'd2);
        fetch_valid = 1'b1; fetch_pc = 32'h200;
        step();
        fetch_valid = 1'b0;
        chk("c_idx", 32'(pred_idx), 32'd1);
        chk("c_next", pred_next_pc, 32'h300);
        chk("c_taken", 32'(pred_taken), 32'd1);
        do_reset();

        // Fill the FIFO with misses
        ent_valid = '0;
        pred_ready = 1'b1;
        fetch_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fetch_pc = 32'h1000 + 32'(k) * 32'h10;
            step();
        end
        fetch_pc = 32'h1050;
        chk("d_full", 32'(q_full), 32'd1);
        chk("d_pc5", pred_pc, 32'h1040);
        chk("d_ready", 32'(fetch_ready), 32'd0);
        step();
        chk("d_hold_pc", pred_pc, 32'h1040);
        chk("d_hold_valid", 32'(pred_valid), 32'd1);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        chk("d_pop_not_full", 32'(q_full), 32'd0);
        chk("d_push_blocked", pred_pc, 32'h1040);
        chk("d_pop_no_redirect", 32'(redirect), 32'd0);
        step();
        fetch_valid = 1'b0;
        chk("d_refull", 32'(q_full), 32'd1);
        chk("d_next_accept", pred_pc, 32'h1050);
        do_reset();

        // Mispredict: head predicted 44, resolves taken to 100
        set_ent(2, 1'b1, 32'h40, 32'h100, 2'd1);
        pred_ready = 1'b1;
        fetch_valid = 1'b1; fetch_pc = 32'h40;
        step();
        fetch_pc = 32'h80;
        step();
        fetch_valid = 1'b0; pred_ready = 1'b0;
        chk("e_pending", 32'(pred_valid), 32'd1);
        res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h100;
        step();
        res_taken = 1'b0;
        chk("e_redirect", 32'(redirect), 32'd1);
        chk("e_redirect_pc", redirect_pc, 32'h100);
        chk("e_flush_valid", 32'(pred_valid), 32'd0);
        chk("e_err_clear", 32'(err_underflow), 32'd0);
        step();
        res_valid = 1'b0;
        chk("e_one_cycle", 32'(redirect), 32'd0);
        chk("e_underflow", 32'(err_underflow), 32'd1);
        step(); step();
        chk("e_sticky", 32'(err_underflow), 32'd1);

        // Asynchronous reset with a lookup in flight
        fetch_valid = 1'b1; fetch_pc = 32'h40; pred_ready = 1'b0;
        step();
        fetch_valid = 1'b0;
        chk("f_inflight", 32'(pred_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("f_rst_valid", 32'(pred_valid), 32'd0);
        chk("f_rst_err", 32'(err_underflow), 32'd0);
        chk("f_rst_pc", pred_pc, 32'h0);
        chk("f_rst_hit", 32'(pred_hit), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
